// File: rtl/ecg_sample_capture.sv
// ECG sample capture: synchronizes the divided sample tick, tags each ADC word with a
// sequence index and buffers it in a first-word-fall-through FIFO for the filter stage.
module ecg_sample_capture #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       switch,
    input  logic                       clk_d,
    input  logic [DATA_W-1:0]          adc_data,
    output logic [DATA_W-1:0]          sample_data,
    output logic [IDX_W-1:0]           sample_idx,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic               r_sw_s1;
    logic               r_sw_s2;
    logic               r_ck_s1;
    logic               r_ck_s2;
    logic               r_ck_d3;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_idx;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_last_data;
    logic [IDX_W-1:0]   r_last_idx;

    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [IDX_W-1:0]   r_mem_idx  [DEPTH];

    logic               w_tick;
    logic               w_sw;
    logic               w_arm_clear;
    logic               w_push_req;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1 <= 1'b0;
            r_sw_s2 <= 1'b0;
            r_ck_s1 <= 1'b0;
            r_ck_s2 <= 1'b0;
            r_ck_d3 <= 1'b0;
        end else begin
            r_sw_s1 <= switch;
            r_sw_s2 <= r_sw_s1;
            r_ck_s1 <= clk_d;
            r_ck_s2 <= r_ck_s1;
            r_ck_d3 <= r_ck_s2;
        end
    end

    assign w_tick = r_ck_s2 & ~r_ck_d3;
    assign w_sw   = r_sw_s2;

    // Dropping the enable wins over a coincident tick: nothing is pushed on the way out.
    always_comb begin
        w_state_next = r_state;
        w_arm_clear  = 1'b0;
        w_push_req   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_sw) begin
                    w_state_next = StArm;
                    w_arm_clear  = 1'b1;
                end
            end
            StArm: begin
                if (!w_sw) begin
                    w_state_next = StIdle;
                end else if (w_tick) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (!w_sw) begin
                    w_state_next = StIdle;
                end else if (w_tick) begin
                    w_push_req = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = sample_ready & ~w_empty;
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_last_data <= '0;
            r_last_idx  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_last_data <= r_mem_data[r_rd_ptr];
                r_last_idx  <= r_mem_idx[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A dropped sample still consumes an index so the gap is visible downstream.
            if (w_arm_clear) begin
                r_idx <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push_req) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= adc_data;
            r_mem_idx[r_wr_ptr]  <= r_idx;
        end
    end

    // When empty the last popped entry is shown so the outputs never glitch to stale slots.
    assign sample_valid = ~w_empty;
    assign sample_data  = w_empty ? r_last_data : r_mem_data[r_rd_ptr];
    assign sample_idx   = w_empty ? r_last_idx : r_mem_idx[r_rd_ptr];
    assign fifo_count   = r_count;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_ecg_sample_capture.sv
// Bench for ecg_sample_capture: queue-based reference model of the capture/FIFO behaviour,
// driven with directed scenarios and randomized clk_d/ready/switch traffic.
module tb_ecg_sample_capture;

    localparam int DATA_W  = 12;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int IDX_MOD = 1 << IDX_W;
    localparam int MIdle   = 0;
    localparam int MArm    = 1;
    localparam int MRun    = 2;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              switch;
    logic              clk_d;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] sample_data;
    logic [IDX_W-1:0]  sample_idx;
    logic              sample_valid;
    logic              sample_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    int ck_half = 4;
    int ck_ph   = 0;
    int rise_n  = 0;
    bit adc_seq = 0;
    bit rand_half = 0;

    ent_t m_q[$];
    ent_t exp_xfer[$];
    ent_t dut_xfer[$];
    int   m_mode = MIdle;
    int   m_idx  = 0;
    bit   m_ovf  = 0;
    ent_t m_last = '0;
    int   m_run_ticks = 0;
    bit   m_ck[3];
    bit   m_sw[2];

    always #5 clk = ~clk;

    ecg_sample_capture #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switch      (switch),
        .clk_d       (clk_d),
        .adc_data    (adc_data),
        .sample_data (sample_data),
        .sample_idx  (sample_idx),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    // Reference model: a sample is taken when clk_d, seen two edges ago, had just risen.
    always @(posedge clk) begin : model
        bit tk;
        bit sw;
        if (rst) begin
            m_q.delete();
            m_mode = MIdle;
            m_idx = 0;
            m_ovf = 0;
            m_last = '0;
            m_run_ticks = 0;
            m_ck[0] = 0; m_ck[1] = 0; m_ck[2] = 0;
            m_sw[0] = 0; m_sw[1] = 0;
        end else begin
            tk = m_ck[1] && !m_ck[2];
            sw = m_sw[1];
            if (m_q.size() > 0 && sample_ready) begin
                m_last = m_q.pop_front();
                exp_xfer.push_back(m_last);
            end
            if (m_mode == MIdle) begin
                if (sw) begin
                    m_mode = MArm;
                    m_idx = 0;
                    m_ovf = 0;
                end
            end else if (!sw) begin
                m_mode = MIdle;
            end else if (tk) begin
                if (m_mode == MArm) begin
                    m_mode = MRun;
                end else begin
                    m_run_ticks++;
                    if (m_q.size() < DEPTH) m_q.push_back({IDX_W'(m_idx), adc_data});
                    else m_ovf = 1;
                    m_idx = (m_idx + 1) % IDX_MOD;
                end
            end
            m_ck[2] = m_ck[1]; m_ck[1] = m_ck[0]; m_ck[0] = clk_d;
            m_sw[1] = m_sw[0]; m_sw[0] = switch;
        end
    end

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) dut_xfer.push_back({sample_idx, sample_data});
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
        ck_ph++;
        if (ck_ph >= ck_half) begin
            ck_ph = 0;
            clk_d = ~clk_d;
            if (clk_d) begin
                rise_n++;
                adc_data = adc_seq ? DATA_W'(32'h100 + rise_n) : DATA_W'($urandom);
                if (rand_half) ck_half = $urandom_range(2, 6);
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1;
        tick_clk();
        tick_clk();
        rst = 0;
        switch = 0;
        sample_ready = 0;
        clk_d = 0;
        ck_ph = 0;
        ck_half = 4;
        rise_n = 0;
        adc_seq = 0;
        rand_half = 0;
        exp_xfer.delete();
        dut_xfer.delete();
    endtask

    task automatic test_reset();
        rst = 1;
        tick_clk();
        tick_clk();
        @(negedge clk);
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", sample_valid); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (sample_data !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", sample_data); end
        total++; if (sample_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", sample_idx); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_basic_capture();
        reset_dut();
        adc_seq = 1;
        sample_ready = 1;
        switch = 1;
        repeat (80) begin
            tick_clk();
            @(negedge clk);
            total++;
            if (fifo_count !== CNT_W'(m_q.size()) || fifo_count > 1) begin
                bad++; $display("FAIL basic_count: got %0d want %0d (max 1)", fifo_count, m_q.size());
            end
        end
        tick_clk();
        total++; if (dut_xfer.size() < 5 || dut_xfer.size() != exp_xfer.size()) begin
            bad++; $display("FAIL basic_xfer_count: got %0d want %0d (at least 5)", dut_xfer.size(), exp_xfer.size());
        end
        if (dut_xfer.size() > 0) begin
            total++; if (dut_xfer[0] !== ent_t'({IDX_W'(0), DATA_W'(12'h102)})) begin
                bad++; $display("FAIL basic_first: got idx %0d data %0h want idx 0 data 102", dut_xfer[0].idx, dut_xfer[0].data);
            end
        end
        for (int i = 0; i < dut_xfer.size() && i < exp_xfer.size(); i++) begin
            total++; if (dut_xfer[i] !== exp_xfer[i] || dut_xfer[i].data !== DATA_W'(32'h102 + i)) begin
                bad++; $display("FAIL basic_xfer[%0d]: got %0h want %0h", i, dut_xfer[i], exp_xfer[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        int want_cnt;
        reset_dut();
        switch = 1;
        n = 0;
        while (m_run_ticks < 10 && n < 300) begin
            tick_clk();
            n++;
            @(negedge clk);
            want_cnt = (m_run_ticks > DEPTH) ? DEPTH : m_run_ticks;
            total++; if (fifo_count !== CNT_W'(want_cnt)) begin
                bad++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, want_cnt);
            end
            total++; if (overflow !== (m_run_ticks >= DEPTH + 1)) begin
                bad++; $display("FAIL ovf_flag: got %0b after %0d ticks", overflow, m_run_ticks);
            end
            if (want_cnt > 0) begin
                total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %0b want 1", sample_valid); end
            end
        end
        total++; if (n >= 300) begin bad++; $display("FAIL ovf_timeout: got %0d ticks want 10", m_run_ticks); end
        sample_ready = 1;
        repeat (20) tick_clk();
        total++; if (dut_xfer.size() < 9) begin bad++; $display("FAIL ovf_drain_size: got %0d want >=9", dut_xfer.size()); end
        for (int i = 0; i < 9 && i < dut_xfer.size() && i < exp_xfer.size(); i++) begin
            total++; if (dut_xfer[i].idx !== IDX_W'(i < 8 ? i : 10) || dut_xfer[i] !== exp_xfer[i]) begin
                bad++; $display("FAIL ovf_drain[%0d]: got %0h want idx %0d / %0h", i, dut_xfer[i], (i < 8 ? i : 10), exp_xfer[i]);
            end
        end
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        int n;
        bit done;
        reset_dut();
        switch = 1;
        n = 0;
        while (m_q.size() < DEPTH && n < 300) begin tick_clk(); n++; end
        total++; if (n >= 300) begin bad++; $display("FAIL fullpop_fill: got %0d want %0d", m_q.size(), DEPTH); end
        dut_xfer.delete();
        exp_xfer.delete();
        done = 0;
        n = 0;
        while (!done && n < 50) begin
            sample_ready = (m_mode == MRun) && m_ck[1] && !m_ck[2];
            if (sample_ready) done = 1;
            tick_clk();
            sample_ready = 0;
            n++;
        end
        @(negedge clk);
        total++; if (!done) begin bad++; $display("FAIL fullpop_timeout: got no tick want one"); end
        total++; if (fifo_count !== CNT_W'(DEPTH)) begin bad++; $display("FAIL fullpop_count: got %0d want %0d", fifo_count, DEPTH); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow: got %0b want 0", overflow); end
        total++; if (dut_xfer.size() != 1) begin bad++; $display("FAIL fullpop_xfer: got %0d want 1", dut_xfer.size()); end
    endtask

    task automatic test_switch_toggle();
        int n;
        int c0;
        reset_dut();
        switch = 1;
        n = 0;
        while (!m_ovf && n < 300) begin tick_clk(); n++; end
        while (m_q.size() > 3 && n < 400) begin
            sample_ready = (m_q.size() > 3);
            tick_clk();
            n++;
        end
        sample_ready = 0;
        total++; if (n >= 400) begin bad++; $display("FAIL toggle_setup: got %0d entries want 3", m_q.size()); end
        switch = 0;
        repeat (3) tick_clk();
        c0 = m_q.size();
        repeat (40) begin
            tick_clk();
            @(negedge clk);
            total++; if (fifo_count !== CNT_W'(c0)) begin
                bad++; $display("FAIL toggle_idle_count: got %0d want %0d", fifo_count, c0);
            end
        end
        sample_ready = 1;
        repeat (6) tick_clk();
        @(negedge clk);
        total++; if (fifo_count !== '0 || sample_valid !== 1'b0) begin
            bad++; $display("FAIL toggle_drain: got count %0d valid %0b want 0 0", fifo_count, sample_valid);
        end
        dut_xfer.delete();
        exp_xfer.delete();
        switch = 1;
        repeat (60) tick_clk();
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL toggle_ovf_clear: got %0b want 0", overflow); end
        tick_clk();
        total++; if (dut_xfer.size() < 3 || dut_xfer.size() != exp_xfer.size()) begin
            bad++; $display("FAIL toggle_rearm_size: got %0d want %0d", dut_xfer.size(), exp_xfer.size());
        end
        for (int i = 0; i < dut_xfer.size() && i < exp_xfer.size(); i++) begin
            total++; if (dut_xfer[i] !== exp_xfer[i] || dut_xfer[i].idx !== IDX_W'(i)) begin
                bad++; $display("FAIL toggle_rearm[%0d]: got %0h want %0h idx %0d", i, dut_xfer[i], exp_xfer[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reset_dut();
        switch = 1;
        n = 0;
        while (m_q.size() < 5 && n < 300) begin tick_clk(); n++; end
        total++; if (fifo_count !== CNT_W'(5)) begin bad++; $display("FAIL rstmid_pre: got %0d want 5", fifo_count); end
        rst = 1;
        tick_clk();
        @(negedge clk);
        total++; if (sample_valid !== 1'b0 || fifo_count !== '0) begin
            bad++; $display("FAIL rstmid_fifo: got valid %0b count %0d want 0 0", sample_valid, fifo_count);
        end
        total++; if (sample_data !== '0 || sample_idx !== '0) begin
            bad++; $display("FAIL rstmid_out: got data %0h idx %0d want 0 0", sample_data, sample_idx);
        end
        rst = 0;
        switch = 0;
    endtask

    task automatic test_index_wrap();
        int n;
        reset_dut();
        ck_half = 3;
        sample_ready = 1;
        switch = 1;
        n = 0;
        while (m_run_ticks < 18 && n < 400) begin tick_clk(); n++; end
        repeat (3) tick_clk();
        total++; if (dut_xfer.size() != 18) begin bad++; $display("FAIL wrap_size: got %0d want 18", dut_xfer.size()); end
        for (int i = 0; i < dut_xfer.size() && i < exp_xfer.size(); i++) begin
            total++; if (dut_xfer[i].idx !== IDX_W'(i % 16) || dut_xfer[i] !== exp_xfer[i]) begin
                bad++; $display("FAIL wrap[%0d]: got %0h want idx %0d / %0h", i, dut_xfer[i], i % 16, exp_xfer[i]);
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        rand_half = 1;
        switch = 1;
        repeat (3000) begin
            sample_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) switch = ~switch;
            tick_clk();
            @(negedge clk);
            total++; if (fifo_count !== CNT_W'(m_q.size()) || sample_valid !== (m_q.size() != 0)) begin
                bad++; $display("FAIL rand_occ: got count %0d valid %0b want %0d", fifo_count, sample_valid, m_q.size());
            end
            total++; if ({sample_idx, sample_data} !== ((m_q.size() != 0) ? m_q[0] : m_last)) begin
                bad++; $display("FAIL rand_head: got %0h want %0h", {sample_idx, sample_data},
                                (m_q.size() != 0) ? m_q[0] : m_last);
            end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf: got %0b want %0b", overflow, m_ovf); end
        end
        tick_clk();
        total++; if (dut_xfer.size() != exp_xfer.size()) begin
            bad++; $display("FAIL rand_xfer_size: got %0d want %0d", dut_xfer.size(), exp_xfer.size());
        end
        for (int i = 0; i < dut_xfer.size() && i < exp_xfer.size(); i++) begin
            total++; if (dut_xfer[i] !== exp_xfer[i]) begin
                bad++; $display("FAIL rand_xfer[%0d]: got %0h want %0h", i, dut_xfer[i], exp_xfer[i]);
            end
        end
    endtask

    initial begin
        rst = 1;
        switch = 0;
        clk_d = 0;
        adc_data = '0;
        sample_ready = 0;
        test_reset();
        test_basic_capture();
        test_overflow();
        test_full_pop();
        test_switch_toggle();
        test_reset_mid();
        test_index_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecg_sample_capture.md
Name: ecg_sample_capture

Overview:
- Consumes the divided sample clock `clk_d` from the clock-divider stage and the acquisition enable `switch`.
- On every rising edge of `clk_d`, captures one ADC word and tags it with a sequence index.
- Buffers tagged samples in a small FIFO and presents them to the downstream ECG filter over a valid/ready stream.
- Everything runs on the single system clock; `clk_d` is treated as a slow data signal, never as a clock.

Parameters:
- DATA_W, 12: ADC sample width.
- DEPTH, 8: FIFO depth in entries; must be a power of 2, ≥2.
- IDX_W, 16: sequence index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- switch  in  1  acquisition enable; asynchronous level, synchronized internally
- clk_d  in  1  divided sample tick from the clock divider; asynchronous level, synchronized internally
- adc_data  in  DATA_W  ADC word; stable around `clk_d` rising edges
- sample_data  out  DATA_W  FIFO head sample
- sample_idx  out  IDX_W  sequence index of the head sample
- sample_valid  out  1  head entry present
- sample_ready  in  1  downstream accepts the head entry
- fifo_count  out  $clog2(DEPTH)+1  occupancy, range 0..DEPTH
- overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (`rst` = 1 at a `clk` edge):
  - state = IDLE; FIFO emptied.
  - `sample_valid`=0, `sample_data`=0, `sample_idx`=0, `fifo_count`=0, `overflow`=0.
  - Synchronizer and edge-detect flops = 0.
  - Reset mid-operation discards all buffered samples.
- Synchronizers:
  - `switch` and `clk_d` each pass through 2 flops (s1→s2).
  - `clk_d` s2 feeds a third delay flop d3.
  - tick = s2 & ~d3: exactly one cycle per `clk_d` rise.
  - With `clk_d` first sampled high at edge k, tick is high in the cycle after edge k+1, and `adc_data` is captured at edge k+2.
  - A `clk_d` high or low phase shorter than 2 `clk` cycles is unsupported.
- FSM (on synchronized switch, sw_s):
  - IDLE: no captures. sw_s=1 → ARM; on that transition the index counter and `overflow` clear to 0.
  - ARM: discards the `clk_d` phase already in progress. The first tick pushes nothing and moves to RUN. sw_s=0 → IDLE.
  - RUN: every tick pushes {idx, adc_data}, then idx increments. sw_s=0 → IDLE.
  - Index wraps from 2^IDX_W−1 to 0 with no flag.
  - Leaving RUN does not flush the FIFO; remaining entries stay poppable.
- Push timing: an entry pushed at edge e makes `sample_valid`=1 and places it on `sample_data`/`sample_idx` after edge e, provided the FIFO was empty (first-word-fall-through).
- Output handshake:
  - Transfer occurs when `sample_valid` & `sample_ready` at a `clk` edge.
  - While `sample_valid`=1 and `sample_ready`=0, `sample_data` and `sample_idx` hold stable.
  - `sample_valid` never deasserts without a transfer, except on reset.
  - `sample_ready` is ignored when empty.
  - `sample_data`/`sample_idx` hold their last value when empty.
- Occupancy:
  - `fifo_count` is registered.
  - Push-only: +1. Pop-only: −1. Push and pop in the same cycle: unchanged.
  - Pointers wrap modulo DEPTH.
- Full:
  - A tick with count=DEPTH and no simultaneous pop drops the sample and sets `overflow`=1.
  - The index still increments, so the downstream sees a gap.
  - A tick with count=DEPTH and a simultaneous pop is accepted; count stays DEPTH.
- `overflow` clears only on `rst` or on the IDLE→ARM transition.
- Empty: a pop request when count=0 has no effect.
- ADC timing: `adc_data` must be stable for at least 3 `clk` cycles after the `clk_d` rising edge.

Test Plan:
- Basic capture: `clk` 10 ns, `clk_d` period 8 clk, `switch` 0→1, `sample_ready`=1, `adc_data` = 0x100+n at the nth `clk_d` rise → first captured sample is from the 2nd rise after arming (ARM discard); indices 0,1,2,… with `sample_data` 0x102,0x103,…; `fifo_count` never exceeds 1.
- Backpressure/overflow: DEPTH=8, `sample_ready`=0 for 10 ticks in RUN → `fifo_count`=8 with `sample_valid`=1 throughout; `overflow`=1 after the 9th tick. Then `sample_ready`=1 → 8 entries drain with indices 0..7, the next accepted index is 10, and `overflow` stays 1.
- Simultaneous push/pop at full: count=8, force a tick in the same cycle as a pop → count remains 8 and `overflow` stays 0.
- Switch toggle: `switch` 1→0 with 3 entries buffered → FSM reaches IDLE and further `clk_d` edges push nothing. The 3 entries drain. `switch` 0→1 → idx restarts at 0, `overflow`=0, and the first post-ARM tick is discarded.
- Reset mid-run: assert `rst` for 1 cycle with 5 entries buffered → next cycle `sample_valid`=0, `fifo_count`=0, `sample_data`=0, `sample_idx`=0, state IDLE.
- Index wrap: IDX_W=4, 18 ticks in RUN with `sample_ready`=1 → indices 0..15, 0, 1 in order.
